// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
// Default widths, reset PC, fetch FSM states and buffer entry.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 64;
  localparam int FETCH_INSTR_W = 32;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] word;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory-side req/ack bus and decode-side valid/ready bus
// of the instruction fetch unit.
interface fetch_mem_if
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_ADDR_W,
  parameter int DW = FETCH_INSTR_W
);
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memAck;
  logic [DW-1:0] memData;

  modport master (
    output memReq, memAddr,
    input  memAck, memData
  );
  modport slave (
    input  memReq, memAddr,
    output memAck, memData
  );
endinterface

interface fetch_dec_if
  import fetch_pkg::*;
#(
  parameter int AW = FETCH_ADDR_W,
  parameter int DW = FETCH_INSTR_W
);
  logic          instrValid;
  logic          instrReady;
  logic [DW-1:0] instruction;
  logic [AW-1:0] PC;
  logic [AW-1:0] PC4;

  modport master (
    output instrValid, instruction, PC, PC4,
    input  instrReady
  );
  modport slave (
    input  instrValid, instruction, PC, PC4,
    output instrReady
  );
endinterface

// File: rtl/instruction_fetch_unit_fifo.sv
// Fetch buffer: power-of-2 synchronous FIFO with flush,
// occupancy count and combinational head read.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = fetch_entry_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, single-outstanding memory FSM and decode buffer.
// FETCH_ALIGN_CHECK_EN: misaligned redirects fault and halt issue.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = FETCH_RESET_PC,
  parameter int          FIFO_DEPTH  = 2,
  parameter int          ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int          INSTR_WIDTH = FETCH_INSTR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  fetch_mem_if.master           mem,
  fetch_dec_if.master           dec,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] PCin,
  output logic                  alignFault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0]  pc;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_after;
  logic                  push, pop, valid, halt;
  entry_t                head, wdata;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign fault_d = fault_q |
    (redirect && (PCin[1:0] != 2'b00));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
  assign halt       = fault_d;
  assign alignFault = fault_q;
`else
  assign halt       = 1'b0;
  assign alignFault = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Occupancy once this cycle's ack is pushed and head popped
  assign cnt_after = cnt + CW'(1) - CW'(pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!halt && (redirect ||
            cnt < CW'(FIFO_DEPTH)))
          state_d = REQ;
      end
      REQ: begin
        if (redirect) begin
          if (!mem.memAck)  state_d = DISCARD;
          else if (halt)    state_d = IDLE;
        end else if (mem.memAck) begin
          if (cnt_after >= CW'(FIFO_DEPTH))
            state_d = IDLE;
        end
      end
      DISCARD: begin
        if (mem.memAck)
          state_d = halt ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem.memReq  = (state_q == REQ);
    mem.memAddr = mem.memReq ? fetch_pc_q : '0;
    push        = mem.memReq && mem.memAck &&
                  !redirect;
    pop         = valid && dec.instrReady;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = PCin & ~ADDR_WIDTH'(3);
    else if (push)
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
  end

  assign wdata.word = mem.memData;
  assign wdata.pc   = fetch_pc_q;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  (wdata),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (cnt)
  );

  assign valid           = (cnt != '0);
  assign dec.instrValid  = valid;
  assign dec.instruction = valid ? head.word : '0;
  assign dec.PC          = valid ? head.pc : '0;
  assign dec.PC4         = valid ?
    head.pc + ADDR_WIDTH'(4) : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a
// variable-latency memory model and a decode consumer.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect;
  logic [63:0] PCin;
  logic        alignFault;

  fetch_mem_if mif ();
  fetch_dec_if dif ();

  instruction_fetch_unit dut (
    .clock      (clock),
    .reset      (reset),
    .mem        (mif),
    .dec        (dif),
    .redirect   (redirect),
    .PCin       (PCin),
    .alignFault (alignFault)
  );

  always #5 clock = ~clock;

  int ntests = 0;
  int nfail  = 0;

  logic [95:0] sbq [$];
  logic [63:0] exp_addr;
  logic [63:0] maddr;
  logic [63:0] last_req_addr;
  logic [63:0] first_pc;
  logic [63:0] wrap_pc4;
  logic [31:0] wnum;
  logic        mbusy, started, watch, saw_wrap;
  logic        last_ack, last_pop;
  logic        nx_rdy, nx_redir;
  logic [63:0] nx_pc;
  int          mcnt, ack_delay;
  int          nreq, npush;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic        ack;
    logic [31:0] w;
    logic [95:0] e;
    @(posedge clock);
    #1;
    ack     = 1'b0;
    w       = 32'hAAAA0000 + wnum;
    started = 1'b0;
    if (!mbusy && mif.memReq) begin
      mbusy   = 1'b1;
      mcnt    = 0;
      maddr   = mif.memAddr;
      started = 1'b1;
      last_req_addr = maddr;
      nreq++;
      chk("req_addr", maddr, exp_addr);
    end else if (mbusy && mif.memReq) begin
      chk("addr_hold", mif.memAddr, maddr);
    end
    if (mbusy) begin
      if (mcnt >= ack_delay) begin
        ack   = 1'b1;
        mbusy = 1'b0;
        wnum++;
      end else begin
        mcnt++;
      end
    end
    mif.memAck     = ack;
    mif.memData    = ack ? w : 32'h0;
    dif.instrReady = nx_rdy;
    redirect       = nx_redir;
    PCin           = nx_pc;
    last_ack       = ack;
    last_pop       = dif.instrValid && nx_rdy;
    if (last_pop) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("instr", {32'h0, dif.instruction},
            {32'h0, e[95:64]});
        chk("pc", dif.PC, e[63:0]);
        chk("pc4", dif.PC4, e[63:0] + 64'd4);
      end
      if (watch) begin
        first_pc = dif.PC;
        watch    = 1'b0;
      end
      if (dif.PC == 64'hFFFF_FFFF_FFFF_FFFC) begin
        saw_wrap = 1'b1;
        wrap_pc4 = dif.PC4;
      end
    end
    if (nx_redir) begin
      sbq.delete();
      exp_addr = nx_pc & ~64'h3;
      watch    = 1'b1;
      first_pc = '1;
    end else if (ack && mif.memReq) begin
      sbq.push_back({w, maddr});
      exp_addr = maddr + 64'd4;
      npush++;
    end
    nx_redir = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    mif.memAck     = 1'b0;
    mif.memData    = '0;
    dif.instrReady = 1'b0;
    redirect       = 1'b0;
    PCin           = '0;
    nx_rdy   = 1'b0;
    nx_redir = 1'b0;
    nx_pc    = '0;
    mbusy    = 1'b0;
    watch    = 1'b0;
    exp_addr = '0;
    sbq.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", {63'h0, mif.memReq}, 64'd0);
    chk("rst_addr", mif.memAddr, 64'd0);
    chk("rst_valid", {63'h0, dif.instrValid}, 64'd0);
    chk("rst_instr", {32'h0, dif.instruction}, 64'd0);
    chk("rst_pc", dif.PC, 64'd0);
    chk("rst_pc4", dif.PC4, 64'd0);
    chk("rst_fault", {63'h0, alignFault}, 64'd0);
    reset = 1'b1;
  endtask

  initial begin
    int p0, r0, k;
    wnum = 0; nreq = 0; npush = 0;
    ack_delay = 0; saw_wrap = 1'b0;
    wrap_pc4 = '1; first_pc = '1;

    // back-to-back streaming
    do_reset();
    nx_rdy = 1'b1;
    cycle();
    chk("first_req", {63'h0, mif.memReq}, 64'd1);
    chk("first_ack", {63'h0, last_ack}, 64'd1);
    cycle();
    chk("ack_latency", {63'h0, dif.instrValid}, 64'd1);
    repeat (10) cycle();

    // decode stall fills the buffer
    do_reset();
    p0 = npush;
    repeat (10) cycle();
    chk("stall_acks", 64'(npush - p0), 64'd2);
    chk("stall_req", {63'h0, mif.memReq}, 64'd0);
    chk("stall_valid", {63'h0, dif.instrValid}, 64'd1);
    chk("stall_pc", dif.PC, 64'd0);
    nx_rdy = 1'b1;
    cycle();
    nx_rdy = 1'b0;
    r0 = nreq;
    cycle();
    chk("stall_pc_next", dif.PC, 64'd4);
    repeat (10) cycle();
    chk("stall_one_req", 64'(nreq - r0), 64'd1);
    chk("stall_req_addr", last_req_addr, 64'd8);

    // redirect while the request to 0x8 is outstanding
    do_reset();
    nx_rdy = 1'b1;
    ack_delay = 3;
    k = 0;
    while (!(started && maddr == 64'd8) && k < 60) begin
      cycle();
      k++;
    end
    chk("p3_reach", {63'h0, started}, 64'd1);
    nx_redir = 1'b1;
    nx_pc    = 64'h100;
    cycle();
    cycle();
    chk("discard_req", {63'h0, mif.memReq}, 64'd0);
    k = 0;
    while (watch && k < 60) begin
      cycle();
      k++;
    end
    chk("redir_first_pc", first_pc, 64'h100);

    // redirect with ack and pop in the same cycle
    do_reset();
    ack_delay = 0;
    nx_rdy = 1'b1;
    repeat (5) cycle();
    nx_redir = 1'b1;
    nx_pc    = 64'h200;
    cycle();
    chk("same_cyc_cond", {62'h0, last_ack, last_pop},
        64'd3);
    cycle();
    chk("same_cyc_empty", {63'h0, dif.instrValid}, 64'd0);
    chk("same_cyc_req", {63'h0, mif.memReq}, 64'd1);
    chk("same_cyc_addr", mif.memAddr, 64'h200);
    repeat (5) cycle();

    // PC wrap at the top of the address space
    nx_redir = 1'b1;
    nx_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    repeat (8) cycle();
    chk("wrap_seen", {63'h0, saw_wrap}, 64'd1);
    chk("wrap_pc4", wrap_pc4, 64'd0);

    // misaligned redirect target
    nx_redir = 1'b1;
    nx_pc    = 64'h102;
    cycle();
    cycle();
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", {63'h0, alignFault}, 64'd1);
    r0 = nreq;
    repeat (20) cycle();
    chk("fault_no_req", 64'(nreq - r0), 64'd0);
    chk("fault_valid", {63'h0, dif.instrValid}, 64'd0);
    chk("fault_sticky", {63'h0, alignFault}, 64'd1);
`else
    chk("align_nofault", {63'h0, alignFault}, 64'd0);
    k = 0;
    while (watch && k < 60) begin
      cycle();
      k++;
    end
    chk("align_first_pc", first_pc, 64'h100);
`endif

    // reset asserted mid-request
    do_reset();
    cycle();
    chk("mid_req", {63'h0, mif.memReq}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {63'h0, mif.memReq}, 64'd0);
    chk("mid_rst_valid", {63'h0, dif.instrValid},
        64'd0);

    $display("[TB] %0d tests run, %0d failed",
             ntests, nfail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Front-end stage directly upstream of the Processor decode/control path. It owns the fetch program counter and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered with their PC and PC+4 in a small FIFO, then presented to decode through a valid/ready interface. Branch/jump resolution from the datapath redirects fetch and flushes stale words.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
FIFO_DEPTH, 2, fetch buffer entries; power of 2, minimum 2
ADDR_WIDTH, 64, PC/address width
INSTR_WIDTH, 32, instruction word width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
memReq  output  1  instruction memory read request, level
memAddr  output  ADDR_WIDTH  word address of the request; stable while memReq=1 and no memAck
memAck  input  1  one-cycle pulse; memData valid in the same cycle
memData  input  INSTR_WIDTH  returned instruction word
instrValid  output  1  head FIFO entry available to decode
instrReady  input  1  decode accepts the head entry this cycle
instruction  output  INSTR_WIDTH  head entry word
PC  output  ADDR_WIDTH  address of the head entry
PC4  output  ADDR_WIDTH  head PC + 4
redirect  input  1  one-cycle pulse: taken branch/jump
PCin  input  ADDR_WIDTH  redirect target
alignFault  output  1  sticky misaligned-target flag (FETCH_ALIGN_CHECK_EN only; otherwise tied 0)

Behaviour:
- Reset (reset=0, asynchronous): fetchPC=RESET_PC, FIFO empty, state=IDLE. memReq, instrValid, alignFault and all data outputs are 0.
- At most one outstanding memory request. Issue condition: fifoCount + outstanding < FIFO_DEPTH.
- States:
  - IDLE -> REQ when the issue condition holds and no fault exists.
  - REQ: memReq=1, memAddr=fetchPC. On memAck: push {memData, fetchPC}, fetchPC += 4. If space remains, stay in REQ with the new address next cycle (back-to-back), else go to IDLE.
  - DISCARD: memReq=0. Wait for memAck, drop its data, then go to REQ at the redirected fetchPC.
- Redirect (any state): FIFO flushed and fetchPC=PCin with bits[1:0] cleared, both next cycle. Transitions: REQ with no ack this cycle -> DISCARD; REQ with ack this cycle -> word dropped, then REQ; IDLE -> REQ.
- Priority: redirect > memAck push > instrReady pop. A pop in the redirect cycle is still the consumer's acceptance of the current head. No FIFO effect occurs after the flush.
- Output: instrValid = FIFO non-empty. instruction/PC/PC4 are driven combinationally from the head. Pop when instrValid && instrReady. Push and pop in the same cycle are legal; count is unchanged.
- PC4 = PC + 4 modulo 2^ADDR_WIDTH. fetchPC wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 silently.
- Latency: memAck in cycle N -> instrValid in cycle N+1. First memReq occurs in the first clock after reset deassertion.
- Reset asserted mid-request: the request is abandoned and memReq drops immediately. The memory must tolerate a dropped request.

Optional Feature:
FETCH_ALIGN_CHECK_EN:
- Defined: a redirect with PCin[1:0] != 0 sets alignFault, flushes the FIFO and halts issue. Any outstanding ack is still drained via DISCARD. alignFault stays set until reset.
- Undefined: the low bits are silently cleared, alignFault is tied 0 and no fault logic is built.

Decomposition:
- Package fetch_pkg: ADDR_WIDTH/INSTR_WIDTH defaults, RESET_PC default, fetch state enum (IDLE, REQ, DISCARD), FIFO entry struct {word, pc}.
- Sub-module fetch_fifo: synchronous FIFO with flush, count, push/pop and head read. The top holds the FSM, PC logic and fault logic.

Test Plan:
- Reset release, memory acks every cycle with 32'hAAAA0000+n, instrReady=1 -> memAddr 0,4,8,... back-to-back; instrValid from the cycle after the first ack; PC4 = PC+4.
- instrReady=0 with FIFO_DEPTH=2 -> exactly 2 acks accepted, memReq low, PC=0 held. Then instrReady=1 for 1 cycle -> head PC=4 and exactly one new request at addr 8.
- Redirect PCin=64'h100 while a request to 0x8 is outstanding, ack 3 cycles later -> that data is dropped; next memAddr=0x100; first delivered PC=0x100; no stale word delivered.
- Redirect in the same cycle as memAck and pop -> FIFO empty next cycle; fetch resumes at PCin.
- fetchPC=64'hFFFF_FFFF_FFFF_FFFC -> delivered PC4=0; next memAddr=0.
- PCin=64'h102: with FETCH_ALIGN_CHECK_EN -> alignFault=1, no further memReq until reset. Without it -> fetch from 0x100, alignFault=0.
